// File: rtl/or_rand_sched.sv
// Kicks a bank of or_rand generators together, captures each result into a slot and drains the
// slots round-robin over one valid/ready port. Optional OR_SCHED_TIMEOUT_EN adds a capture timeout.
module or_rand_sched #(
  parameter int NREP    = 4,
  parameter int TIMEOUT = 64,
  parameter int OPT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NREP-1:0]           rep_en,
  output logic                      busy,
  output logic                      done,
  output logic [NREP-1:0]           rand_run,
  output logic [NREP-1:0]           rand_opt_en,
  input  logic [NREP-1:0]           rand_ready,
  input  logic [NREP*OPT_W-1:0]     rand_opt,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [OPT_W-1:0]          o_opt,
  output logic [$clog2(NREP)-1:0]   o_rep,
  output logic                      err
);

  localparam int RW = $clog2(NREP);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_KICK    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [NREP-1:0] en_q, en_d;
  logic [NREP-1:0] pending_q, pending_d;
  logic [NREP-1:0] wait_q, wait_d;
  logic [NREP-1:0] full_q, full_d;
  logic [NREP-1:0] cap;
  logic [OPT_W-1:0] slot_q [NREP];
  logic [RW-1:0]   rr_q, rr_d, gnt_idx, rep_q;
  logic [OPT_W-1:0] opt_q;
  logic            gnt_found, adv, tmo;
  logic            busy_q, busy_d, done_q, done_d, valid_q, valid_d;

`ifdef OR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  // All replicas are kicked in the same cycle, so one shared counter tracks every pending slot.
  assign tmo = (state_q == S_COLLECT) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_KICK) cnt_q <= '0;
      else if (state_q == S_COLLECT && !tmo) cnt_q <= cnt_q + CW'(1);
      if (state_q == S_IDLE && start) err_q <= 1'b0;
      else if (tmo && |(pending_q & ~cap)) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // A slot captures on the first ready after ready has been seen low since the kick.
  assign cap = pending_q & wait_q & rand_ready;
  assign adv = !valid_q || o_ready;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREP; k++) begin
      if (!gnt_found && full_q[(int'(rr_q) + k) % NREP]) begin
        gnt_found = 1'b1;
        gnt_idx   = RW'((int'(rr_q) + k) % NREP);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    pending_d = pending_q & ~cap;
    wait_d    = wait_q | (pending_q & ~rand_ready);
    full_d    = full_q | cap;
    rr_d      = rr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;

    if (tmo) pending_d = '0;

    if (adv) begin
      if (gnt_found) begin
        valid_d         = 1'b1;
        full_d[gnt_idx] = 1'b0;
        rr_d            = (gnt_idx == RW'(NREP - 1)) ? '0 : gnt_idx + RW'(1);
      end else begin
        valid_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d = rep_en;
          if (rep_en == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_KICK;
          end
        end
      end
      S_KICK: begin
        pending_d = en_q;
        wait_d    = '0;
        state_d   = S_COLLECT;
      end
      S_COLLECT: begin
        if (pending_q == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (full_q == '0 && adv) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      en_q      <= '0;
      pending_q <= '0;
      wait_q    <= '0;
      full_q    <= '0;
      rr_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      opt_q     <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      full_q    <= full_d;
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      if (adv && gnt_found) begin
        opt_q <= slot_q[gnt_idx];
        rep_q <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREP; i++) begin
      if (cap[i]) slot_q[i] <= rand_opt[i*OPT_W +: OPT_W];
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rand_run    = {NREP{state_q == S_KICK}};
  assign rand_opt_en = en_q;
  assign o_valid     = valid_q;
  assign o_opt       = opt_q;
  assign o_rep       = rep_q;

endmodule
